// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM states,
// RISC-V load/store funct3 codes and byte-lane / alignment helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we)
      return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else
      return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
             (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

  // Illegal encodings are folded into "misaligned" so they never reach the bus.
  function automatic logic is_misaligned(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic misal;
    misal = 1'b0;
    if (!is_legal(we, funct3))
      misal = 1'b1;
    else begin
      case (funct3[1:0])
        2'b01:   misal = addr_lo[0];
        2'b10:   misal = (addr_lo != 2'b00);
        default: misal = 1'b0;
      endcase
    end
    return misal;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001 << addr_lo;
      2'b01:   sel = 4'b0011 << {addr_lo[1], 1'b0};
      2'b10:   sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] dat;
    case (size)
      2'b00:   dat = {4{wdata[7:0]}};
      2'b01:   dat = {2{wdata[15:0]}};
      default: dat = wdata;
    endcase
    return dat;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_unit.sv
// Load formatter: picks the addressed byte/half/word out of a bus word and
// zero- or sign-extends it according to the load funct3.
module mem_access_ctrl_load_unit
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] rdata
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = data[{addr_lo, 3'b000} +: 8];
    half_val = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_LB:   rdata = {{24{byte_val[7]}}, byte_val};
      F3_LH:   rdata = {{16{half_val[15]}}, half_val};
      F3_LW:   rdata = data;
      F3_LBU:  rdata = {24'h0, byte_val};
      F3_LHU:  rdata = {16'h0, half_val};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: one outstanding load/store at a time onto a
// Wishbone-style bus, with alignment checking, lane steering and a bus timeout.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_misal_o,
  output logic        rsp_fault_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       rd_data;
  logic              misal_q;
  logic              fault_q;
  logic [TO_W-1:0]   to_cnt;
  logic              accept;
  logic              misal_now;
  logic              bus_fault;
  logic              bus_active;
  logic [31:0]       lu_rdata;

  assign accept     = (state == ST_IDLE) && req_valid_i;
  assign misal_now  = is_misaligned(req_we_i, req_funct3_i, req_addr_i[1:0]);
  // err beats ack; a timeout only counts when no ack arrives in that same cycle
  assign bus_fault  = wb_err_i || ((to_cnt == TO_LAST) && !wb_ack_i);
  assign bus_active = (state == ST_BUS);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid_i) state_nxt = misal_now ? ST_RESP : ST_BUS;
      ST_BUS:  if (wb_ack_i || bus_fault) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_we     <= 1'b0;
      req_funct3 <= 3'b000;
      req_addr   <= 32'h0;
      req_wdata  <= 32'h0;
      rd_data    <= 32'h0;
      misal_q    <= 1'b0;
      fault_q    <= 1'b0;
      to_cnt     <= '0;
    end else if (accept) begin
      req_we     <= req_we_i;
      req_funct3 <= req_funct3_i;
      req_addr   <= req_addr_i;
      req_wdata  <= req_wdata_i;
      misal_q    <= misal_now;
      fault_q    <= 1'b0;
      to_cnt     <= '0;
    end else if (bus_active) begin
      if (bus_fault) begin
        fault_q <= 1'b1;
        to_cnt  <= '0;
      end else if (wb_ack_i) begin
        rd_data <= wb_dat_i;
        to_cnt  <= '0;
      end else begin
        to_cnt  <= to_cnt + TO_W'(1);
      end
    end
  end

  mem_access_ctrl_load_unit u_load_unit (
    .data    (rd_data),
    .funct3  (req_funct3),
    .addr_lo (req_addr[1:0]),
    .rdata   (lu_rdata)
  );

  // Bus outputs decode straight from state so reset drops cyc/stb asynchronously.
  always_comb begin
    req_ready_o = (state == ST_IDLE);
    rsp_valid_o = (state == ST_RESP);
    rsp_misal_o = (state == ST_RESP) && misal_q;
    rsp_fault_o = (state == ST_RESP) && fault_q;
    rsp_rdata_o = 32'h0;
    if ((state == ST_RESP) && !req_we && !misal_q && !fault_q)
      rsp_rdata_o = lu_rdata;
    wb_cyc_o = bus_active;
    wb_stb_o = bus_active;
    wb_we_o  = bus_active && req_we;
    wb_adr_o = 32'h0;
    wb_sel_o = 4'b0000;
    wb_dat_o = 32'h0;
    if (bus_active) begin
      wb_adr_o = {req_addr[31:2], 2'b00};
      wb_sel_o = lane_sel(req_funct3[1:0], req_addr[1:0]);
      wb_dat_o = lane_data(req_funct3[1:0], req_wdata);
    end
  end

endmodule
